// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Parametrised valid/ready pipeline stage register. Carries a DATA_W-bit
//   payload between two pipeline stages. With SKID_EN=1 a second (skid)
//   entry lets in_ready_o come straight from the state register. With
//   SKID_EN=0 the stage holds one entry and in_ready_o is combinational
//   from out_ready_i. flush_i drops every beat held in the stage.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (wins over flush_i)
//   flush_i      empties the stage at the next edge
//   in_valid_i   upstream beat valid
//   in_ready_o   stage can take a beat this cycle
//   in_data_i    upstream payload
//   out_valid_o  out_data_o holds a valid beat
//   out_ready_i  downstream takes the beat
//   out_data_o   payload to downstream (main register)
//   occ_o        number of entries held (0..2)
module pipe_stage_skid #(
  parameter int unsigned       DATA_W   = 64,
  parameter logic [DATA_W-1:0] RST_DATA = '0,
  parameter bit                SKID_EN  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  // Encoding equals occupancy, so occ_o is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire, out_fire;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign occ_o       = state_q;

  // SKID_EN is a constant, so with the skid present in_ready_o depends on
  // state_q only and out_ready_i never reaches it.
  assign in_ready_o = SKID_EN ? (state_q != ST_SKID)
                              : (~out_valid_o | out_ready_i);

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // Next-state / main-register datapath. Flush is handled here; reset is in
  // the register process. Nothing loads from in_data_i without in_fire,
  // so bubbles never disturb the stored payload.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = RST_DATA;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = in_data_i;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            // Downstream stalled: park the new beat behind the current one.
            if (SKID_EN) state_d = ST_SKID;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = RST_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic skid_ld;
      // Skid content is don't-care outside SKID, so no reset and no flush.
      assign skid_ld = in_fire & ~out_fire & (state_q == ST_FULL);
      always_ff @(posedge clk_i) begin
        if (skid_ld) skid_q <= in_data_i;
      end
    end else begin : g_noskid
      assign skid_q = RST_DATA;
    end
  endgenerate

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register, successor to the fixed IF/ID latch.
- Carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake.
- Adds two features the old latch lacked:
  - an optional skid entry, so upstream ready is fully registered;
  - a flush input that drops all in-flight beats.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB; the payload is packed by the instantiating stage (e.g. {pc, inst}).

Parameters:
- DATA_W, 64, payload width in bits (≥1).
- RST_DATA, 0, value loaded into out_data_o on reset and on flush (DATA_W bits).
- SKID_EN, 1:
  - 1 = two-entry skid buffer with registered in_ready_o;
  - 0 = single entry with combinational in_ready_o.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- flush_i, input, 1: squash; empties the stage at the next edge.
- in_valid_i, input, 1: upstream beat valid (low = bubble).
- in_ready_o, output, 1: stage can accept a beat this cycle.
- in_data_i, input, DATA_W: upstream payload.
- out_valid_o, output, 1: out_data_o holds a valid beat.
- out_ready_i, input, 1: downstream accepts the beat (low = stall).
- out_data_o, output, DATA_W: payload to the downstream stage.
- occ_o, output, 2: entries held (0, 1 or 2).

Behaviour:
- Fire rules:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- Storage: main register (drives out_data_o) plus skid register. The skid register is present only when SKID_EN=1.
- States: EMPTY (occ 0), FULL (occ 1), SKID (occ 2; reachable only when SKID_EN=1).
- Outputs per state:
  - out_valid_o = (state != EMPTY).
  - SKID_EN=1: in_ready_o = (state != SKID), a pure function of the state register.
  - SKID_EN=0: in_ready_o = ~out_valid_o | out_ready_i.
- Transitions, when flush_i and rst_i are both low:
  - EMPTY: in_fire → FULL, main <= in_data_i. Otherwise stay.
  - FULL, in_fire & out_fire → FULL, main <= in_data_i.
  - FULL, in_fire & ~out_fire → SKID, skid <= in_data_i; main unchanged. Only possible with SKID_EN=1.
  - FULL, ~in_fire & out_fire → EMPTY; main data held.
  - FULL, neither fires → FULL; main held (stall).
  - SKID, out_fire → FULL, main <= skid. in_ready_o is 0 in SKID, so no input is taken.
  - SKID, ~out_fire → stay; both entries held.
- Ordering: beats leave in arrival order. No beat is ever duplicated or lost except on flush or reset.
- Registers not loaded in a cycle retain their value, including main while EMPTY.
- Flush:
  - flush_i high at an edge → state EMPTY, out_data_o <= RST_DATA, skid content don't-care.
  - Any beat offered in that cycle is discarded, even if in_fire was true.
  - A beat taken by downstream in that cycle (out_fire) counts as delivered.
  - in_ready_o is 1 in the cycle after a flush.
- Reset: rst_i high at an edge gives the same result as flush, from any state including SKID. rst_i has priority over flush_i.
- Reset values: out_valid_o=0, out_data_o=RST_DATA, occ_o=0, in_ready_o=1.
- Latency: one cycle from in_fire to out_valid_o in an empty stage. Zero-bubble throughput of 1 beat/cycle when out_ready_i stays high.
- Combinational paths:
  - No combinational path from in_valid_i or in_data_i to any output.
  - SKID_EN=1: no path from out_ready_i to in_ready_o.
- X-safety: in_data_i is ignored when in_valid_i is low; bubbles never load.

Test Plan:
- Streaming: SKID_EN=1; reset, then in_valid_i=1 for 4 cycles with data 0x11,0x22,0x33,0x44 and out_ready_i=1 → out_data_o shows 0x11..0x44 on consecutive cycles starting 1 cycle after the first in_fire; occ_o stays 1; in_ready_o stays 1.
- Stall into skid: SKID_EN=1; load 0xA0, then drop out_ready_i while offering 0xB0 → occ_o=2, in_ready_o=0, out_data_o holds 0xA0. Raise out_ready_i for 2 cycles → outputs 0xA0 then 0xB0, occ_o returns to 0.
- Flush: flush in SKID with a new beat 0xC0 offered → next cycle out_valid_o=0, out_data_o=RST_DATA, occ_o=0, in_ready_o=1. 0xC0 never appears at the output.
- Bubbles: in_valid_i=0 with in_data_i=0xDEAD for 3 cycles from EMPTY → out_valid_o remains 0, out_data_o unchanged.
- No skid: SKID_EN=0; stall with out_ready_i=0 while FULL → in_ready_o=0 the same cycle; occ_o never exceeds 1; release → in_ready_o=1 combinationally.
- Reset priority: assert rst_i and flush_i together in SKID state → all outputs at reset values next cycle. Also confirm rst_i alone mid-stream empties the stage.
